bisquare_o_b: RTL and testbench
===============================

// Module: bisquare_o_b
// PURPOSE
//  Bipolar-in/bipolar-out stochastic squarer: the forward counterpart of the bipolar sqrt kernel.
//  Squares the input by XNOR-ing each input bit with a decorrelated copy of an earlier input bit.
//  The copy is drawn from a DEP-entry shuffle buffer addressed by an external random index.
//  Sits in the kernel layer beside the sqrt kernels; its input and output are bipolar bitstreams.
// PARAMETERS
//  DEP      4  shuffle buffer depth; power of two, >= 2
//  DEPLOG   2  log2(DEP); width of randNum
// PORTS
//  clk      input   1       clock, rising edge
//  rst_n    input   1       asynchronous reset, active low
//  randNum  input   DEPLOG  random buffer index; a fresh value every cycle
//  in       input   1       bipolar input bitstream, x = 2*P(in)-1
//  out      output  1       bipolar output bitstream, x^2 = 2*P(out)-1
//  primed   output  1       high once DEP input bits have been written into the buffer
// BEHAVIOUR
//  - Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
//  - Reset (async, immediate):
//    - buf[i] <= i[0], i.e. pattern 0,1,0,1,... (encodes bipolar zero)
//    - cnt <= 0, out <= 0, primed <= 0, tog <= 0
//  - Every cycle with rst_n=1:
//    - rd = buf[randNum]
//    - buf[randNum] <= in; the read slot is replaced, so read and write hit the same entry
//    - out <= ~(in ^ rd); out is registered, latency 1 cycle
//    - cnt <= (cnt==DEP) ? DEP : cnt+1; cnt is DEPLOG+1 bits wide and saturates
//    - primed <= (cnt+1 >= DEP); primed first rises on the edge that performs the DEP-th write
//  - Same-cycle read and write: the read returns the OLD buf contents, never `in`.
//    The buffer uses no write-through.
//  - randNum is always < DEP because DEP = 2^DEPLOG; no range check is needed.
//  - Reset mid-stream: all state returns to reset values at once, the buffer pattern is restored
//    and priming starts again.
//  - No handshake: one input bit is consumed and one output bit produced per cycle, continuously.
//  - Accuracy depends on the decorrelation from randNum.
//    A constant randNum gives out = in XNOR in delayed, where the delay is the slot's reuse distance.
// CONFIGURATION
//  BISQUARE_WARMUP_MASK_EN
//   - Defined: while primed==0, out <= tog and tog <= ~tog, which emits a bipolar-zero 0,1,0,1 stream.
//     `in` is still written to the buffer.
//     Once primed, out uses the normal XNOR path; tog is unused and holds its value.
//   - Undefined: out is always ~(in ^ rd), including during warm-up. tog is not instantiated.
// TESTING
//  1 Reset: hold rst_n=0 -> out=0, primed=0; the buffer reads back 0,1,0,1 at randNum=0..3.
//  2 in=1 constant, randNum=0,1,2,3,0,1,... (mask off) -> out=0,1,0,1 on cycles 1-4,
//    then 1 forever; primed=1 from cycle 4.
//  3 in=0 constant, same randNum sequence -> out=1,0,1,0 on cycles 1-4, then 1 forever,
//    since (-1)^2 = +1.
//  4 in = LFSR comparator at P=0.75 (x=0.5), randNum = independent 8-bit LFSR[1:0],
//    4096 cycles -> P(out) = 0.625 +/- 0.03.
//  5 Pull rst_n low at cycle 100 for half a cycle, without waiting for a clock edge
//    -> out=0 and primed=0 immediately.
//    After release, primed re-rises exactly DEP cycles later.
//  6 BISQUARE_WARMUP_MASK_EN defined, in=1 constant -> out=0,1,0,1 for the first DEP cycles
//    regardless of in, then 1 forever.

Source files
------------

// File: rtl/bisquare_o_b_if.sv
// Bitstream port bundle for the bipolar stochastic squarer: random index and input
// bit from the source side, squared bit and primed flag back.
interface bisquare_o_b_if #(
  parameter int DEPLOG = 2
);
  logic [DEPLOG-1:0] randNum;
  logic              in;
  logic              out;
  logic              primed;

  modport master (output randNum, output in, input out, input primed);
  modport slave  (input randNum, input in, output out, output primed);
endinterface

// File: rtl/bisquare_o_b.sv
// Bipolar stochastic squarer: XNOR of each input bit with a shuffled earlier input bit.
// Optional BISQUARE_WARMUP_MASK_EN replaces the output with a 0,1,0,1 stream until primed.
module bisquare_o_b #(
  parameter int DEP    = 4,
  parameter int DEPLOG = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  bisquare_o_b_if.slave  bus
);

  logic [DEP-1:0]  shuf_reg;
  logic [DEPLOG:0] cnt_reg;
  logic            out_reg;
  logic            primed_reg;
  logic            rd;
  logic [DEPLOG+1:0] cnt_inc;

  // Read sees the pre-edge contents; the same slot is overwritten on the edge.
  assign rd      = shuf_reg[bus.randNum];
  assign cnt_inc = {1'b0, cnt_reg} + (DEPLOG+2)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Alternating pattern so an unprimed buffer reads as bipolar zero.
      for (int i = 0; i < DEP; i++) begin
        shuf_reg[i] <= 1'(i % 2);
      end
    end else begin
      shuf_reg[bus.randNum] <= bus.in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      primed_reg <= 1'b0;
    end else begin
      cnt_reg    <= (cnt_reg == (DEPLOG+1)'(DEP)) ? cnt_reg : cnt_inc[DEPLOG:0];
      primed_reg <= (cnt_inc >= (DEPLOG+2)'(DEP));
    end
  end

`ifdef BISQUARE_WARMUP_MASK_EN
  logic tog_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg <= 1'b0;
      tog_reg <= 1'b0;
    end else if (!primed_reg) begin
      out_reg <= tog_reg;
      tog_reg <= ~tog_reg;
    end else begin
      out_reg <= ~(bus.in ^ rd);
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg <= 1'b0;
    end else begin
      out_reg <= ~(bus.in ^ rd);
    end
  end
`endif

  assign bus.out    = out_reg;
  assign bus.primed = primed_reg;

endmodule

// File: tb/tb_bisquare_o_b.sv
// Self-checking bench for bisquare_o_b against a bipolar-squaring reference model.
module tb_bisquare_o_b;

  localparam int DEP    = 4;
  localparam int DEPLOG = 2;
`ifdef BISQUARE_WARMUP_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  bisquare_o_b_if #(.DEPLOG(DEPLOG)) bus ();

  bisquare_o_b #(.DEP(DEP), .DEPLOG(DEPLOG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: the buffer as a plain array of earlier input bits.
  int m_buf [DEP];
  int m_cnt;
  int m_out;
  int m_primed;
  int m_tog;

  function automatic void model_reset();
    for (int i = 0; i < DEP; i++) m_buf[i] = i % 2;
    m_cnt    = 0;
    m_out    = 0;
    m_primed = 0;
    m_tog    = 0;
  endfunction

  function automatic void model_step(input int x, input int r);
    int old;
    old      = m_buf[r];
    m_buf[r] = x;
    if (MASK && m_primed == 0) begin
      m_out = m_tog;
      m_tog = 1 - m_tog;
    end else begin
      m_out = (x == old) ? 1 : 0;
    end
    m_primed = (m_cnt + 1 >= DEP) ? 1 : 0;
    m_cnt    = (m_cnt + 1 > DEP) ? DEP : m_cnt + 1;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic x, input logic [DEPLOG-1:0] r);
    bus.in      = x;
    bus.randNum = r;
    @(posedge clk);
    model_step(int'(x), int'(r));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.in      = 1'b1;
    bus.randNum = '0;
    do_reset();
    n_checks++;
    if (bus.out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: got %b want 0", bus.out);
    end
    n_checks++;
    if (bus.primed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_primed: got %b want 0", bus.primed);
    end
    $display("test_reset: out=%b primed=%b", bus.out, bus.primed);
  endtask

  // Constant input, sweeping slots 0..3 then repeating; exp_first is the fresh-buffer readout.
  task automatic test_const(input logic x, input logic [3:0] exp_first);
    logic exp;
    logic exp_p;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step(x, DEPLOG'(k - 1));
      if (MASK) exp = (k <= DEP) ? 1'((k - 1) % 2) : 1'b1;
      else      exp = (k <= DEP) ? exp_first[k-1] : 1'b1;
      exp_p = (k >= DEP);
      n_checks++;
      if (bus.out !== exp) begin
        n_fail++;
        $display("FAIL const_out in=%b cyc=%0d: got %b want %b", x, k, bus.out, exp);
      end
      n_checks++;
      if (bus.primed !== exp_p) begin
        n_fail++;
        $display("FAIL const_primed in=%b cyc=%0d: got %b want %b", x, k, bus.primed, exp_p);
      end
      $display("test_const in=%b cyc=%0d out=%b primed=%b", x, k, bus.out, bus.primed);
    end
  endtask

  task automatic test_random(input int cycles);
    logic x;
    logic [DEPLOG-1:0] r;
    do_reset();
    for (int k = 0; k < cycles; k++) begin
      x = 1'($urandom_range(1));
      r = DEPLOG'($urandom_range(DEP - 1));
      step(x, r);
      n_checks++;
      if (bus.out !== 1'(m_out) || bus.primed !== 1'(m_primed)) begin
        n_fail++;
        $display("FAIL random cyc=%0d: got out=%b primed=%b want out=%0d primed=%0d",
                 k, bus.out, bus.primed, m_out, m_primed);
      end
      $display("test_random cyc=%0d in=%b r=%0d out=%b", k, x, r, bus.out);
    end
  endtask

  // x = 0.5 in, expect x^2 = 0.25, i.e. P(out) = 0.625.
  task automatic test_statistics();
    int ones;
    real p;
    logic x;
    ones = 0;
    do_reset();
    for (int k = 0; k < 4096; k++) begin
      x = ($urandom_range(3) != 0);
      step(x, DEPLOG'($urandom_range(DEP - 1)));
      if (bus.out === 1'b1) ones++;
    end
    p = real'(ones) / 4096.0;
    n_checks++;
    if (p < 0.595 || p > 0.655) begin
      n_fail++;
      $display("FAIL stat_p_out: got %f want 0.625+/-0.03", p);
    end
    $display("test_statistics: P(out)=%f", p);
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 100; k++) step(1'($urandom_range(1)), DEPLOG'($urandom_range(DEP - 1)));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out !== 1'b0 || bus.primed !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got out=%b primed=%b want 0 0", bus.out, bus.primed);
    end
    $display("test_async_reset: mid-cycle out=%b primed=%b", bus.out, bus.primed);
    #1;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    for (int k = 1; k <= DEP + 2; k++) begin
      step(1'($urandom_range(1)), DEPLOG'($urandom_range(DEP - 1)));
      n_checks++;
      if (bus.primed !== (k >= DEP) || bus.out !== 1'(m_out)) begin
        n_fail++;
        $display("FAIL reprime cyc=%0d: got primed=%b out=%b want primed=%b out=%0d",
                 k, bus.primed, bus.out, (k >= DEP), m_out);
      end
      $display("test_async_reset reprime cyc=%0d primed=%b", k, bus.primed);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.in      = 1'b0;
    bus.randNum = '0;
    @(negedge clk);
    test_reset();
    test_const(1'b1, 4'b1010);
    test_const(1'b0, 4'b0101);
    test_random(300);
    test_statistics();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
